clock_time_keeper: RTL and testbench

//  Downstream consumer of the 1 ms toggle generator. Turns each transition of the incoming

---
 rtl/clock_time_keeper_pkg.sv | 25 ++
 rtl/clock_time_keeper_bcd_mod_counter.sv | 57 +++++
 rtl/clock_time_keeper.sv | 112 +++++++++++
 tb/tb_clock_time_keeper.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_time_keeper_pkg.sv
// Shared constants and BCD helpers for the time-of-day keeper and its display decoder.
package clock_time_keeper_pkg;

  localparam int BCD2_W = 8;   // two-digit field (hours, minutes, seconds)
  localparam int BCD3_W = 12;  // three-digit field (milliseconds)

  localparam logic [BCD3_W-1:0] MS_WRAP_DEF   = 12'h999;
  localparam logic [BCD2_W-1:0] SEC_WRAP      = 8'h59;
  localparam logic [BCD2_W-1:0] MIN_WRAP      = 8'h59;
  localparam logic [BCD2_W-1:0] HOUR_WRAP_DEF = 8'h23;

  // True when both nibbles are decimal digits and the value does not exceed max_val.
  // For well-formed BCD a plain binary compare orders values correctly.
  function automatic logic bcd2_valid(input logic [BCD2_W-1:0] v,
                                      input logic [BCD2_W-1:0] max_val);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_val);
  endfunction

  // Two-digit BCD increment without wrap handling (caller decides on wrap).
  function automatic logic [BCD2_W-1:0] bcd2_inc(input logic [BCD2_W-1:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/clock_time_keeper_bcd_mod_counter.sv
// Multi-digit BCD modulo counter: counts 0..WRAP, raises carry on the wrapping increment.
// Priority: clr > load > inc. Reset is synchronous, active-low.
module clock_time_keeper_bcd_mod_counter #(
  parameter int                    DIGITS = 2,
  parameter logic [4*DIGITS-1:0]   WRAP   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  inc_i,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic                  carry_o
);

  logic [4*DIGITS-1:0] value_q, value_d, inc_val;

  // Ripple a +1 through the decimal digits; each 9 rolls to 0 and passes the carry on.
  always_comb begin
    logic c;
    // NOTE: combinational blocks use blocking '=' and assign every output first, so the
    // loop sees updated values and no latch can be inferred.
    inc_val = value_q;
    c       = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (inc_val[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = inc_val[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
  end

  // Next-value selection with clear/load/increment priority.
  always_comb begin
    carry_o = inc_i && (value_q == WRAP);
    if (clr_i)        value_d = '0;
    else if (load_i)  value_d = load_val_i;
    else if (carry_o) value_d = '0;
    else if (inc_i)   value_d = inc_val;
    else              value_d = value_q;
  end

  // Counter state register.
  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking '<=' and the reset is sampled on the clock edge.
    if (!rst_n_i) value_q <= '0;
    else          value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/clock_time_keeper.sv
// 24 h BCD time-of-day keeper (HH:MM:SS.mmm) driven by the 1 ms toggle generator.
// Every edge of Millisecond_in is one millisecond tick. Optional alarm comparator is
// compiled in when CLOCK_TIME_ALARM_EN is defined.
module clock_time_keeper
  import clock_time_keeper_pkg::*;
#(
  parameter logic [BCD3_W-1:0] MS_WRAP   = MS_WRAP_DEF,
  parameter logic [BCD2_W-1:0] HOUR_WRAP = HOUR_WRAP_DEF
) (
  input  logic              Clk_50MHz,
  input  logic              Reset_N,
  input  logic              Millisecond_in,
  input  logic              Run_En,
  input  logic              Clear,
  input  logic              Set_Load,
  input  logic [BCD2_W-1:0] Set_Hour,
  input  logic [BCD2_W-1:0] Set_Min,
`ifdef CLOCK_TIME_ALARM_EN
  input  logic [BCD2_W-1:0] Alarm_Hour,
  input  logic [BCD2_W-1:0] Alarm_Min,
  input  logic              Alarm_Arm,
  input  logic              Alarm_Ack,
  output logic              Alarm_out,
`endif
  output logic [BCD2_W-1:0] Hour_BCD,
  output logic [BCD2_W-1:0] Min_BCD,
  output logic [BCD2_W-1:0] Sec_BCD,
  output logic [BCD3_W-1:0] Ms_BCD,
  output logic              Second_Pulse,
  output logic              Day_Pulse,
  output logic              Set_Err
);

  logic ms_q;
  logic second_pulse_q, day_pulse_q, set_err_q;
  logic tick, count_en, set_valid, load_ok, clr_low;
  logic ms_carry, sec_carry, min_carry, hour_carry;

  // Edge detect, priority resolution and load validation.
  always_comb begin
    tick      = Millisecond_in ^ ms_q;
    set_valid = bcd2_valid(Set_Hour, HOUR_WRAP) && bcd2_valid(Set_Min, MIN_WRAP);
    load_ok   = Set_Load && !Clear && set_valid;
    // Clear or any load attempt (valid or not) swallows a coincident tick.
    count_en  = tick && Run_En && !Clear && !Set_Load;
    // Seconds and milliseconds are zeroed by both clear and a successful load.
    clr_low   = Clear || load_ok;
  end

  clock_time_keeper_bcd_mod_counter #(.DIGITS(3), .WRAP(MS_WRAP)) u_ms (
    .clk_i(Clk_50MHz), .rst_n_i(Reset_N), .inc_i(count_en), .clr_i(clr_low),
    .load_i(1'b0), .load_val_i('0), .value_o(Ms_BCD), .carry_o(ms_carry)
  );

  clock_time_keeper_bcd_mod_counter #(.DIGITS(2), .WRAP(SEC_WRAP)) u_sec (
    .clk_i(Clk_50MHz), .rst_n_i(Reset_N), .inc_i(ms_carry), .clr_i(clr_low),
    .load_i(1'b0), .load_val_i('0), .value_o(Sec_BCD), .carry_o(sec_carry)
  );

  clock_time_keeper_bcd_mod_counter #(.DIGITS(2), .WRAP(MIN_WRAP)) u_min (
    .clk_i(Clk_50MHz), .rst_n_i(Reset_N), .inc_i(sec_carry), .clr_i(Clear),
    .load_i(load_ok), .load_val_i(Set_Min), .value_o(Min_BCD), .carry_o(min_carry)
  );

  clock_time_keeper_bcd_mod_counter #(.DIGITS(2), .WRAP(HOUR_WRAP)) u_hour (
    .clk_i(Clk_50MHz), .rst_n_i(Reset_N), .inc_i(min_carry), .clr_i(Clear),
    .load_i(load_ok), .load_val_i(Set_Hour), .value_o(Hour_BCD), .carry_o(hour_carry)
  );

  // Edge register (runs even when stopped) and the registered status pulses.
  always_ff @(posedge Clk_50MHz) begin
    if (!Reset_N) begin
      ms_q           <= 1'b0;
      second_pulse_q <= 1'b0;
      day_pulse_q    <= 1'b0;
      set_err_q      <= 1'b0;
    end else begin
      ms_q           <= Millisecond_in;
      second_pulse_q <= ms_carry;
      day_pulse_q    <= hour_carry;
      set_err_q      <= Set_Load && !Clear && !set_valid;
    end
  end

  assign Second_Pulse = second_pulse_q;
  assign Day_Pulse    = day_pulse_q;
  assign Set_Err      = set_err_q;

`ifdef CLOCK_TIME_ALARM_EN
  logic              alarm_q, alarm_hit;
  logic [BCD2_W-1:0] next_min, next_hour;

  // Time about to be written this cycle, compared against the alarm setting.
  // A tick lands on HH:MM:00.000 exactly when the seconds field wraps.
  always_comb begin
    next_min  = min_carry  ? '0 : bcd2_inc(Min_BCD);
    next_hour = hour_carry ? '0 : (min_carry ? bcd2_inc(Hour_BCD) : Hour_BCD);
    alarm_hit = (load_ok && (Set_Hour == Alarm_Hour) && (Set_Min == Alarm_Min)) ||
                (sec_carry && (next_hour == Alarm_Hour) && (next_min == Alarm_Min));
  end

  // Sticky alarm flag, dropped by acknowledge, disarm or clear.
  always_ff @(posedge Clk_50MHz) begin
    if (!Reset_N)                            alarm_q <= 1'b0;
    else if (Clear || !Alarm_Arm || Alarm_Ack) alarm_q <= 1'b0;
    else if (alarm_hit)                      alarm_q <= 1'b1;
  end

  assign Alarm_out = alarm_q;
`endif

endmodule

// File: tb/tb_clock_time_keeper.sv
// Self-checking bench for clock_time_keeper. The reference keeps time as an integer
// millisecond-of-day and converts to BCD with plain arithmetic.
// Alarm checks are included when CLOCK_TIME_ALARM_EN is defined.
module tb_clock_time_keeper;

  logic       clk = 1'b0;
  logic       Reset_N = 1'b0, Millisecond_in = 1'b0, Run_En = 1'b0;
  logic       Clear = 1'b0, Set_Load = 1'b0;
  logic [7:0] Set_Hour = '0, Set_Min = '0;
  logic [7:0] Hour_BCD, Min_BCD, Sec_BCD;
  logic [11:0] Ms_BCD;
  logic       Second_Pulse, Day_Pulse, Set_Err;
  logic [7:0] Alarm_Hour = '0, Alarm_Min = '0;
  logic       Alarm_Arm = 1'b0, Alarm_Ack = 1'b0;
`ifdef CLOCK_TIME_ALARM_EN
  logic       Alarm_out;
`endif

  clock_time_keeper dut (
    .Clk_50MHz(clk), .Reset_N(Reset_N), .Millisecond_in(Millisecond_in),
    .Run_En(Run_En), .Clear(Clear), .Set_Load(Set_Load),
    .Set_Hour(Set_Hour), .Set_Min(Set_Min),
`ifdef CLOCK_TIME_ALARM_EN
    .Alarm_Hour(Alarm_Hour), .Alarm_Min(Alarm_Min), .Alarm_Arm(Alarm_Arm),
    .Alarm_Ack(Alarm_Ack), .Alarm_out(Alarm_out),
`endif
    .Hour_BCD(Hour_BCD), .Min_BCD(Min_BCD), .Sec_BCD(Sec_BCD), .Ms_BCD(Ms_BCD),
    .Second_Pulse(Second_Pulse), .Day_Pulse(Day_Pulse), .Set_Err(Set_Err)
  );

  always #10 clk = ~clk;

  localparam int DAY_MS = 86_400_000;

  int checks = 0, errors = 0;
  int sp_cnt = 0, dp_cnt = 0;

  // Reference state
  int t_m = 0;
  bit prev_m = 1'b0, sp_m = 1'b0, dp_m = 1'b0, err_m = 1'b0, alarm_m = 1'b0;

  function automatic logic [7:0] dd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [35:0] to_bcd(input int t);
    int h, m, s, ms;
    h  = t / 3_600_000;
    m  = (t / 60_000) % 60;
    s  = (t / 1000) % 60;
    ms = t % 1000;
    return {dd(h), dd(m), dd(s), 4'(ms / 100), dd(ms % 100)};
  endfunction

  // Decode a BCD byte to an integer; -1 when a nibble is not a decimal digit.
  function automatic int from_bcd(input logic [7:0] b);
    int hi, lo;
    hi = int'(b[7:4]);
    lo = int'(b[3:0]);
    if (hi > 9 || lo > 9) return -1;
    return hi * 10 + lo;
  endfunction

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the reference, compare every output.
  task automatic step(input logic rn, input logic mi, input logic run, input logic clr,
                      input logic ld, input logic [7:0] sh, input logic [7:0] sm);
    bit tick, updated;
    int h, m, ah, am;
    Reset_N = rn; Millisecond_in = mi; Run_En = run; Clear = clr;
    Set_Load = ld; Set_Hour = sh; Set_Min = sm;
    @(posedge clk);
    updated = 1'b0;
    if (!rn) begin
      t_m = 0; prev_m = 1'b0; sp_m = 1'b0; dp_m = 1'b0; err_m = 1'b0; alarm_m = 1'b0;
    end else begin
      tick = mi ^ prev_m;
      prev_m = mi;
      sp_m = 1'b0; dp_m = 1'b0; err_m = 1'b0;
      h = from_bcd(sh);
      m = from_bcd(sm);
      if (clr) begin
        t_m = 0;
      end else if (ld) begin
        if (h >= 0 && h <= 23 && m >= 0 && m <= 59) begin
          t_m = h * 3_600_000 + m * 60_000;
          updated = 1'b1;
        end else begin
          err_m = 1'b1;
        end
      end else if (tick && run) begin
        t_m++;
        updated = 1'b1;
        if (t_m % 1000 == 0) sp_m = 1'b1;
        if (t_m == DAY_MS) begin
          t_m = 0;
          dp_m = 1'b1;
        end
      end
      ah = from_bcd(Alarm_Hour);
      am = from_bcd(Alarm_Min);
      if (clr || !Alarm_Arm || Alarm_Ack) alarm_m = 1'b0;
      else if (updated && t_m == ah * 3_600_000 + am * 60_000) alarm_m = 1'b1;
    end
    #1;
    check("time", {Hour_BCD, Min_BCD, Sec_BCD, Ms_BCD}, to_bcd(t_m));
    check("second_pulse", 36'(Second_Pulse), 36'(sp_m));
    check("day_pulse", 36'(Day_Pulse), 36'(dp_m));
    check("set_err", 36'(Set_Err), 36'(err_m));
`ifdef CLOCK_TIME_ALARM_EN
    check("alarm_out", 36'(Alarm_out), 36'(alarm_m));
`endif
    if (Second_Pulse) sp_cnt++;
    if (Day_Pulse)    dp_cnt++;
  endtask

  task automatic toggles(input int n, input logic run);
    for (int i = 0; i < n; i++) step(1'b1, ~Millisecond_in, run, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    // 1: reset held two cycles with busy inputs
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h99, 8'hFF);
    check("reset_time", {Hour_BCD, Min_BCD, Sec_BCD, Ms_BCD}, 36'h0);

    // 2: one second of ticks
    sp_cnt = 0;
    toggles(1000, 1'b1);
    check("one_sec_time", {Sec_BCD, Ms_BCD}, 20'h01000);
    check("one_sec_pulses", 36'(sp_cnt), 36'd1);

    // 3: last minute of the day rolls over (alarm armed for midnight)
    Alarm_Arm = 1'b1; Alarm_Hour = 8'h00; Alarm_Min = 8'h00;
    step(1'b1, Millisecond_in, 1'b1, 1'b0, 1'b1, 8'h23, 8'h59);
    check("load_2359", {Hour_BCD, Min_BCD, Sec_BCD, Ms_BCD}, 36'h235900000);
    sp_cnt = 0; dp_cnt = 0;
    toggles(60000, 1'b1);
    check("midnight_time", {Hour_BCD, Min_BCD, Sec_BCD, Ms_BCD}, 36'h0);
    check("midnight_day_pulses", 36'(dp_cnt), 36'd1);
    check("midnight_sec_pulses", 36'(sp_cnt), 36'd60);
`ifdef CLOCK_TIME_ALARM_EN
    check("alarm_at_midnight", 36'(Alarm_out), 36'd1);
    Alarm_Ack = 1'b1;
    toggles(1, 1'b1);
    Alarm_Ack = 1'b0;
    check("alarm_acked", 36'(Alarm_out), 36'd0);
    Alarm_Hour = 8'h07; Alarm_Min = 8'h15;
    step(1'b1, Millisecond_in, 1'b1, 1'b0, 1'b1, 8'h07, 8'h15);
    check("alarm_via_load", 36'(Alarm_out), 36'd1);
`endif
    Alarm_Arm = 1'b0;
    toggles(250, 1'b1);

    // 4: invalid loads leave time untouched
    step(1'b1, Millisecond_in, 1'b1, 1'b0, 1'b1, 8'h24, 8'h30);
    check("bad_hour_err", 36'(Set_Err), 36'd1);
    step(1'b1, Millisecond_in, 1'b1, 1'b0, 1'b1, 8'h10, 8'h5A);
    check("bad_min_err", 36'(Set_Err), 36'd1);

    // 5: stop, restart without backlog, clear/load colliding with a tick
    toggles(500, 1'b0);
    step(1'b1, Millisecond_in, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    toggles(37, 1'b1);
    step(1'b1, ~Millisecond_in, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check("clear_with_tick", {Hour_BCD, Min_BCD, Sec_BCD, Ms_BCD}, 36'h0);
    toggles(5, 1'b1);
    step(1'b1, ~Millisecond_in, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34);
    check("load_with_tick", {Hour_BCD, Min_BCD, Sec_BCD, Ms_BCD}, 36'h123400000);
    step(1'b1, Millisecond_in, 1'b0, 1'b0, 1'b1, 8'h09, 8'h59);
    check("load_while_stopped", {Hour_BCD, Min_BCD}, 16'h0959);

    // Randomized traffic, including occasional mid-count resets
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] sh, sm;
      if ($urandom_range(1)) begin
        sh = {4'($urandom_range(2)), 4'($urandom_range(9))};
        sm = {4'($urandom_range(6)), 4'($urandom_range(9))};
      end else begin
        sh = 8'($urandom);
        sm = 8'($urandom);
      end
      Alarm_Arm  = ($urandom_range(9) != 0);
      Alarm_Ack  = ($urandom_range(49) == 0);
      Alarm_Hour = sh;
      Alarm_Min  = sm;
      step($urandom_range(299) != 0,
           $urandom_range(3) != 0 ? ~Millisecond_in : Millisecond_in,
           $urandom_range(9) != 0,
           $urandom_range(99) == 0,
           $urandom_range(49) == 0,
           sh, sm);
    end
    Alarm_Arm = 1'b0; Alarm_Ack = 1'b0;

    // Reset in the middle of counting
    toggles(300, 1'b1);
    step(1'b0, ~Millisecond_in, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("mid_reset_time", {Hour_BCD, Min_BCD, Sec_BCD, Ms_BCD}, 36'h0);
    toggles(20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
